// File: rtl/mult32x16_pipe_pkg.sv
// Shared widths for the SID filter datapath.
// Sample and coefficient formats used by the multiplier and filter.
package mult32x16_pipe_pkg;

    localparam int SAMPLE_W  = 32;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 16;
    localparam int HALF_W    = 16;
    localparam int PROD_W    = 2 * HALF_W;

endpackage

// File: rtl/mult32x16_pipe_mul16x16.sv
// 16x16 combinational multiplier with per-operand signedness.
// Maps onto one SB_MAC16 block.
module mult32x16_pipe_mul16x16
    import mult32x16_pipe_pkg::*;
(
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [HALF_W-1:0] a,
    input  logic [HALF_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    logic signed [HALF_W:0]   a_ext;
    logic signed [HALF_W:0]   b_ext;
    logic signed [PROD_W-1:0] prod;

    // A 17-bit signed view covers both interpretations of each operand.
    assign a_ext = {a_signed & a[HALF_W-1], a};
    assign b_ext = {b_signed & b[HALF_W-1], b};
    assign prod  = a_ext * b_ext;
    assign p     = prod;

endmodule

// File: rtl/mult32x16_pipe.sv
// Signed 32-bit sample times unsigned Q0.16 coefficient.
// Result is floor(product / 2^16), registered once.
module mult32x16_pipe
    import mult32x16_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                iRstN,
    input  logic [SAMPLE_W-1:0] iLHS,
    input  logic [COEF_W-1:0]   iRHS,
    output logic [SAMPLE_W-1:0] oOut
);

    logic [PROD_W-1:0]   hi_p;
    logic [PROD_W-1:0]   lo_p;
    logic [SAMPLE_W-1:0] sum;
    logic                lo_unused;
    logic [SAMPLE_W-1:0] out_q = '0;

    mult32x16_pipe_mul16x16 u_hi (
        .a_signed (1'b1),
        .b_signed (1'b0),
        .a        (iLHS[SAMPLE_W-1:HALF_W]),
        .b        (iRHS),
        .p        (hi_p)
    );

    mult32x16_pipe_mul16x16 u_lo (
        .a_signed (1'b0),
        .b_signed (1'b0),
        .a        (iLHS[HALF_W-1:0]),
        .b        (iRHS),
        .p        (lo_p)
    );

    // Low partial product only contributes its carry into the kept bits.
    assign sum = hi_p + {{(SAMPLE_W-PROD_W+COEF_FRAC){1'b0}},
                         lo_p[PROD_W-1:COEF_FRAC]};
    assign lo_unused = ^lo_p[COEF_FRAC-1:0];

    always_ff @(posedge clk) begin
        if (!iRstN) out_q <= '0;
        else        out_q <= sum;
    end

    assign oOut = out_q;

endmodule

// File: tb/tb_mult32x16_pipe.sv
// Self-checking bench for mult32x16_pipe.
// Compares against a 64-bit arithmetic reference.
module tb_mult32x16_pipe;

    logic        clk = 1'b0;
    logic        iRstN;
    logic [31:0] iLHS;
    logic [15:0] iRHS;
    logic [31:0] oOut;

    int errors = 0;
    int checks = 0;

    mult32x16_pipe dut (
        .clk   (clk),
        .iRstN (iRstN),
        .iLHS  (iLHS),
        .iRHS  (iRHS),
        .oOut  (oOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] golden(input logic [31:0] l,
                                           input logic [15:0] r);
        longint lx;
        longint rx;
        longint p;
        lx = longint'($signed(l));
        rx = longint'({48'd0, r});
        p  = lx * rx;
        p  = p >>> 16;
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (oOut === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, oOut, exp);
        end
    endtask

    task automatic step(input logic [31:0] l, input logic [15:0] r,
                        input string tag);
        iLHS = l;
        iRHS = r;
        @(posedge clk);
        #1;
        check(tag, golden(l, r));
    endtask

    task automatic step_const(input logic [31:0] l, input logic [15:0] r,
                              input logic [31:0] exp, input string tag);
        iLHS = l;
        iRHS = r;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    logic [31:0] a_l, b_l, c_l, rl;
    logic [15:0] a_r, b_r, c_r, rr;

    initial begin
        iRstN = 1'b1;
        iLHS  = 32'h1234_5678;
        iRHS  = 16'h4321;
        #1;
        check("powerup", 32'h0);

        iRstN = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 32'h0);
        iRstN = 1'b1;

        step_const(32'h0001_0000, 16'h8000, 32'h0000_8000, "half");
        step_const(32'hFFFF_0000, 16'hFFFF, 32'hFFFF_0001, "neg1_max");
        step_const(32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, "floor_neg");
        step_const(32'h0000_0001, 16'hFFFF, 32'h0000_0000, "floor_pos");
        step_const(32'h7FFF_FFFF, 16'hFFFF, 32'h7FFF_7FFF, "max_lhs");
        step_const(32'h8000_0000, 16'hFFFF, 32'h8000_8000, "min_lhs");
        step_const(32'h8000_0000, 16'h0000, 32'h0000_0000, "rhs0_min");
        step_const(32'h7FFF_FFFF, 16'h0000, 32'h0000_0000, "rhs0_max");
        step_const(32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, "rhs0_rand");
        step_const(32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, "neg1_neg1");

        for (int i = 0; i < 1000; i++) begin
            step($urandom, 16'($urandom), "stream");
        end

        iRstN = 1'b0;
        step_const($urandom, 16'($urandom), 32'h0, "rst_edge1");
        step_const($urandom, 16'($urandom), 32'h0, "rst_edge2");
        iRstN = 1'b1;
        rl = $urandom | 32'h0001_0000;
        rr = 16'($urandom) | 16'h8000;
        step(rl, rr, "rst_release");
        step($urandom, 16'($urandom), "post_release");

        a_l = $urandom; a_r = 16'($urandom);
        b_l = $urandom; b_r = 16'($urandom);
        c_l = $urandom; c_r = 16'($urandom);
        @(posedge clk);
        #1;
        iLHS = a_l; iRHS = a_r;
        @(posedge clk);
        #1;
        iLHS = b_l; iRHS = b_r;
        @(negedge clk);
        check("sched_a", golden(a_l, a_r));
        @(posedge clk);
        @(negedge clk);
        check("sched_b", golden(b_l, b_r));
        @(posedge clk);
        #1;
        iLHS = c_l; iRHS = c_r;
        @(posedge clk);
        @(negedge clk);
        check("sched_c", golden(c_l, c_r));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
